// File: rtl/jk_bank_ctrl_pkg.sv
// Shared types and helpers for the JK bank controller (package jk_ctrl_pkg).
package jk_ctrl_pkg;

  localparam int unsigned JK_OP_W = 2;

  typedef enum logic [JK_OP_W-1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  // Next value of a JK flop given its current value and {j,k}
  function automatic logic jk_next(input logic cur, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      2'b00:   nxt = cur;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      default: nxt = ~cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with synchronous active-low reset.
module jk_cell
  import jk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  // JK state update; reset clears the cell
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= jk_next(q_q, j, k);
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Arbitrated controller applying masked JK commands to a shared bank of JK cells.
// Build option: JK_BANK_CTRL_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin arbitration.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [JK_OP_W*NREQ-1:0]   req_op,
  input  logic [WIDTH*NREQ-1:0]     req_mask,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          q,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id
);

  localparam int unsigned ID_W = $clog2(NREQ);

  ctrl_state_t      state_q;
  jk_op_t           op_q;
  logic [WIDTH-1:0] mask_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  done_id_q;
  logic             done_q;
  logic             busy_q;
`ifndef JK_BANK_CTRL_FIXED_PRIO_EN
  logic [ID_W-1:0]  ptr_q;
`endif

  logic             gnt_vld_c;
  logic [ID_W-1:0]  gnt_idx_c;
  jk_op_t           gnt_op_c;
  logic [WIDTH-1:0] gnt_mask_c;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;

  // Pick the first valid requester at or after the search base
  always_comb begin
    int base;
    int idx;
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    idx       = 0;
`ifdef JK_BANK_CTRL_FIXED_PRIO_EN
    base      = 0;
`else
    base      = int'(ptr_q);
`endif
    for (int off = 0; off < int'(NREQ); off++) begin
      idx = (base + off) % int'(NREQ);
      if (!gnt_vld_c && req_valid[idx]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = ID_W'(idx);
      end
    end
    gnt_op_c   = jk_op_t'(req_op[JK_OP_W*int'(gnt_idx_c) +: JK_OP_W]);
    gnt_mask_c = req_mask[WIDTH*int'(gnt_idx_c) +: WIDTH];
  end

  // One-hot accept strobe, only while idle
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_vld_c) req_ready[gnt_idx_c] = 1'b1;
  end

  // Cell drive: latched op on masked bits during APPLY, hold everywhere else
  always_comb begin
    j_c = '0;
    k_c = '0;
    if (state_q == APPLY) begin
      j_c = (op_q inside {JK_SET, JK_TGL}) ? mask_q : '0;
      k_c = (op_q inside {JK_CLR, JK_TGL}) ? mask_q : '0;
    end
  end

  // Controller FSM with command latch, status outputs and arbitration pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= JK_HOLD;
      mask_q    <= '0;
      id_q      <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
`ifndef JK_BANK_CTRL_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld_c) begin
            op_q    <= gnt_op_c;
            mask_q  <= gnt_mask_c;
            id_q    <= gnt_idx_c;
            busy_q  <= 1'b1;
            state_q <= APPLY;
`ifndef JK_BANK_CTRL_FIXED_PRIO_EN
            ptr_q   <= (int'(gnt_idx_c) == int'(NREQ) - 1) ? '0 : gnt_idx_c + ID_W'(1);
`endif
          end
        end
        APPLY: begin
          done_q    <= 1'b1;
          done_id_q <= id_q;
          state_q   <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bank of JK cells
  for (genvar b = 0; b < int'(WIDTH); b++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_c[b]),
      .k     (k_c[b]),
      .q     (q[b])
    );
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Controller that shares a bank of WIDTH JK flip-flop cells between NREQ requesters. Each requester submits a masked JK command (hold, clear, set or toggle) through a valid/ready handshake. The controller arbitrates between requesters, applies one command per transaction to the masked bits, and reports completion. It sits between software- or FSM-driven control agents and a shared status/flag register built from JK cells.

## Interface
Parameters:
- WIDTH, 8: number of JK cells in the bank (1..32).
- NREQ, 2: number of requesters (2..8).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester command valid.
- req_op  in  2*NREQ  per-requester command, slice i = bits [2i+1:2i], encoded {j,k}.
- req_mask  in  WIDTH*NREQ  per-requester bit mask, slice i = bits [WIDTH*(i+1)-1:WIDTH*i].
- req_ready  out  NREQ  one-hot grant/accept strobe.
- q  out  WIDTH  current bank contents.
- busy  out  1  high while a command is in flight (state != IDLE).
- done  out  1  one-cycle completion pulse.
- done_id  out  $clog2(NREQ)  index of the requester whose command completed; valid only while done=1.

## Operation
- Op encoding, matching JK semantics: 00 hold, 01 clear, 10 set, 11 toggle.
- Masked bits receive {j,k}=op. Unmasked bits receive {j,k}=00 and hold their value.
- FSM states:
  - IDLE: if any req_valid, grant one requester.
    - req_ready[g]=1 combinationally for exactly that requester, with no other ready bit high.
    - On that edge, latch op, mask and id, then go to APPLY.
  - APPLY: drive j/k to the cells for exactly one cycle. The cells update on this edge. Go to DONE.
  - DONE: assert done and done_id. Go to IDLE.
- req_ready is 0 in APPLY and DONE, and 0 in IDLE when no req_valid is set.
- Arbitration (default) is round-robin.
  - Pointer p starts at 0 after reset.
  - Grant the first valid requester at or after p, searching modulo NREQ.
  - After a grant to g, p = (g+1) mod NREQ.
  - p is unchanged when nothing is granted.
- A hold op (00) or a zero mask still completes the full handshake and pulses done. q is unchanged.
- Requesters must hold req_op and req_mask stable while req_valid=1 and not yet accepted. Changes after acceptance have no effect.
- Reset values: q=0, busy=0, done=0, done_id=0, req_ready=0, FSM=IDLE, p=0.
- Reset mid-operation aborts the transaction: no done pulse, q cleared, the command is lost.

## Timing
- Acceptance edge E: req_valid[g] & req_ready[g] high at E.
- q reflects the new value from edge E+1.
- done=1 during the cycle between edges E+1 and E+2.
- The earliest next acceptance is edge E+3, i.e. 3 cycles per transaction.
- busy is high from edge E to edge E+2.
- Toggle on a bit uses that bit's value at edge E+1 (i.e. q as held during APPLY).
- A request whose req_valid rises while busy waits and is considered in the next IDLE cycle.

## Configuration
- JK_BANK_CTRL_FIXED_PRIO_EN.
  - Defined: fixed priority, lowest index wins. Pointer p is not implemented.
  - Undefined: round-robin as in Operation.
- All other behaviour and timing are identical in both builds.

## Structure
- Package jk_ctrl_pkg holds:
  - typedef jk_op_t (2-bit enum: JK_HOLD, JK_CLR, JK_SET, JK_TGL);
  - typedef ctrl_state_t (IDLE, APPLY, DONE);
  - the 2-bit op width constant.
- Sub-module jk_cell is one JK flip-flop with clk, rst_n (sync, active-low, resets q to 0), j, k and q.
  - It is instantiated WIDTH times via generate.
  - Each cell's j/k is driven by the controller: 00 outside APPLY.

## Test plan
- Reset, then req0 set, mask 8'hA5: req_ready=01 at E; q=8'hA5 from E+1; done=1 with done_id=0 in the next cycle; busy low after E+2.
- From q=8'hA5, req1 toggle, mask 8'hFF: q=8'h5A. Then clear, mask 8'h0F: q=8'h50. Then hold, mask 8'hFF: q stays 8'h50, done still pulses.
- Both requesters continuously valid (set, mask 8'h01 and 8'h02): grants alternate 0,1,0,1 with one grant every 3 cycles. With JK_BANK_CTRL_FIXED_PRIO_EN defined, all grants go to 0.
- rst_n low during APPLY: no done pulse, q=0, next grant goes to requester 0.
- Requester changes req_mask after acceptance: the applied mask is the one latched at E.
- Zero mask with toggle from q=8'h3C: q stays 8'h3C, done pulses with the correct done_id.
